spi_slave_regfile: RTL and testbench
====================================

// Module: spi_slave_regfile
// PURPOSE
//  SPI responder (target) for our 100 MHz-clocked SPI master link (sclk = clk/10).
//  Oversamples sclk/cs/mosi in the clk domain, decodes 12-bit frames {rw, addr[2:0], data[7:0]}
//  MSB first, and holds a 2^ADDR_WIDTH x DATA_WIDTH register file. Write frames update it;
//  read frames return the addressed register on miso after the master's turnaround delay.
//  The target board instantiates it behind the SPI pins, and benches use it as the master's loopback partner.
// PARAMETERS
//  RW_FLAG     1   width of the rw field (1 = write, 0 = read)
//  ADDR_WIDTH  3   register address width; register file depth = 2**ADDR_WIDTH
//  DATA_WIDTH  8   register / data field width
//  CMD_WIDTH   RW_FLAG+ADDR_WIDTH+DATA_WIDTH (12)   frame length in bits
// PORTS
//  clk        in   1           system clock, 100 MHz
//  rst        in   1           asynchronous reset, active-high
//  sclk       in   1           SPI clock from master, idle low, async to clk
//  cs         in   1           chip select, active-low, async to clk
//  mosi       in   1           master-out data, valid at sclk rising edge
//  miso       out  1           slave-out data, changes after sclk falling edge
//  wr_valid   out  1           1-clk pulse: a write frame has committed
//  wr_addr    out  ADDR_WIDTH  address of the committed write (held until next commit)
//  wr_data    out  DATA_WIDTH  data of the committed write (held until next commit)
//  frame_err  out  1           1-clk pulse: cs deasserted mid-frame
// BEHAVIOUR
//  - Reset: all registers cleared. Register file = 0. miso=0, wr_valid=0, wr_addr=0, wr_data=0, frame_err=0. FSM in IDLE.
//  - Input sync: sclk, cs, and mosi each pass through a 2-flop synchronizer.
//  - Edge detect: rise/fall are 1-clk strobes taken from the synced sclk versus its 1-clk-delayed copy.
//  - Sampling: mosi is sampled on the synced rise strobe. Sync adds 2-3 clk of lag, inside the master's 5-clk setup.
//  - FSM states: IDLE, CMD, RESP, DONE.
//    - IDLE: wait for synced cs=0, then go to CMD with bit_cnt=0.
//    - CMD: each rise shifts the sampled mosi into cmd_sr (MSB first) and increments bit_cnt.
//    - CMD, on rise #12 (bit_cnt==CMD_WIDTH-1):
//      - rw=1 (write): on the next clk, write regfile[addr] <= data, pulse wr_valid, latch wr_addr/wr_data, go to DONE.
//      - rw=0 (read): on the next clk, load resp_sr <= regfile[addr], go to RESP. The data field is ignored.
//    - RESP: miso = resp_sr[DATA_WIDTH-1].
//      - The first fall after entering RESP is the tail of cmd bit 11; do not shift on it.
//      - After each rise counted in RESP, the following fall shifts resp_sr left by 1.
//      - After 8 rises, go to DONE.
//    - DONE: ignore all sclk edges. miso=0. Go to IDLE when synced cs=1.
//  - The master's 100-clk turnaround (cs low, sclk idle) is absorbed in RESP. No timeout.
//  - cs rises in CMD or RESP (early termination): abort, pulse frame_err, no register write,
//    wr_valid stays 0, go to IDLE. cs rising in DONE or IDLE is normal and gives no error.
//  - miso = 0 whenever the FSM is not in RESP. No tri-state inside this block.
//  - Write then read to the same address in back-to-back frames returns the new value,
//    since the write commits before cs rises.
//  - Address wrap: none. ADDR_WIDTH bits index the file directly, so every address is valid.
//  - An async rst assert mid-frame returns the block to IDLE and clears the register file.
//    The rest of the frame is ignored until the next cs falling edge after rst is released.
// STRUCTURE
//  - Package spi_pkg: RW_FLAG/ADDR_WIDTH/DATA_WIDTH/CMD_WIDTH defaults.
//  - Package spi_pkg: localparams RW_WRITE=1'b1, RW_READ=1'b0, RW_BIT=CMD_WIDTH-1, SYNC_STAGES=2.
//  - Package spi_pkg: FSM state encodings (shared with the master's bench).
//  - Sub-module spi_in_sync: 2-flop sync of {sclk, cs, mosi} plus registered sclk rise/fall strobes.
//  - Top level: FSM, bit counter, cmd_sr, resp_sr, register file.
// TESTING
//  Stimulus is a bench SPI master at clk/10 (sclk high for clk counts 5..9 of each bit) with a 100-clk read turnaround.
//  1. Write 12'b1_101_10100101, addr 5 data 0xA5
//     -> wr_valid one pulse, wr_addr=5, wr_data=0xA5, regfile[5]=0xA5, frame_err=0.
//  2. Write 0xA5 to addr 5, then read frame 12'b0_101_00000000
//     -> bits sampled on miso at each sclk rise = 1,0,1,0,0,1,0,1 (0xA5), no wr_valid.
//  3. Read addr 2 after reset -> 0x00 on miso; then write 0x3C to addr 2 and read it back -> 0x3C.
//  4. cs raised after 6 cmd bits of a write to addr 7 -> frame_err one pulse, regfile[7] unchanged.
//     Then a full write of 0x11 to addr 7 succeeds.
//  5. Write 0xFF to addr 0 and 0x80 to addr 7, then read both -> 0xFF and 0x80, so no aliasing.
//  6. rst pulsed during the RESP phase of a read -> miso=0 immediately, all registers read back 0x00.
//     The next read frame works normally.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI frame constants and FSM state encoding
package spi_pkg;
  localparam int DEF_RW_FLAG    = 1;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CMD_WIDTH  = DEF_RW_FLAG + DEF_ADDR_WIDTH + DEF_DATA_WIDTH;

  localparam logic RW_WRITE    = 1'b1;
  localparam logic RW_READ     = 1'b0;
  localparam int   RW_BIT      = DEF_CMD_WIDTH - 1;
  localparam int   SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } spi_state_e;
endpackage

// File: rtl/spi_in_sync.sv
// rtl/spi_in_sync.sv - synchronizes sclk/cs/mosi into clk and strobes sclk edges
module spi_in_sync
  import spi_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sclk_i,
  input  logic cs_i,
  input  logic mosi_i,
  output logic cs_s_o,
  output logic mosi_s_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q;
  logic sclk_dly_q, rise_q, fall_q;

  // cs resets low so a cs already low at reset release never looks like a new frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q     <= '0;
      cs_q       <= '0;
      mosi_q     <= '0;
      sclk_dly_q <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      sclk_q     <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
      cs_q       <= {cs_q[SYNC_STAGES-2:0], cs_i};
      mosi_q     <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
      sclk_dly_q <= sclk_q[SYNC_STAGES-1];
      rise_q     <= sclk_q[SYNC_STAGES-1] & ~sclk_dly_q;
      fall_q     <= ~sclk_q[SYNC_STAGES-1] & sclk_dly_q;
    end
  end

  assign cs_s_o   = cs_q[SYNC_STAGES-1];
  assign mosi_s_o = mosi_q[SYNC_STAGES-1];
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
endmodule

// File: rtl/spi_slave_regfile.sv
// rtl/spi_slave_regfile.sv - SPI target decoding {rw, addr, data} frames into a register file
module spi_slave_regfile
  import spi_pkg::*;
#(
  parameter int RW_FLAG    = DEF_RW_FLAG,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  wr_valid,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  frame_err
);
  localparam int CMD_WIDTH = RW_FLAG + ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W     = $clog2(CMD_WIDTH);

  logic cs_s, mosi_s, rise, fall;

  spi_in_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .sclk_i  (sclk),
    .cs_i    (cs),
    .mosi_i  (mosi),
    .cs_s_o  (cs_s),
    .mosi_s_o(mosi_s),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  spi_state_e             state_q;
  logic                   cs_prev_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [CMD_WIDTH-2:0]   cmd_sr_q;
  logic [DATA_WIDTH-1:0]  resp_sr_q;
  logic                   resp_armed_q;
  logic                   miso_q, wr_valid_q, frame_err_q;
  logic [ADDR_WIDTH-1:0]  wr_addr_q;
  logic [DATA_WIDTH-1:0]  wr_data_q;
  logic [DATA_WIDTH-1:0]  regs_q [2**ADDR_WIDTH];

  // Full frame as it stands once the current mosi sample is shifted in
  logic [CMD_WIDTH-1:0]   cmd_d;
  logic                   cmd_rw;
  logic [ADDR_WIDTH-1:0]  cmd_addr;
  logic [DATA_WIDTH-1:0]  cmd_data;

  assign cmd_d    = {cmd_sr_q, mosi_s};
  assign cmd_rw   = cmd_d[CMD_WIDTH-1];
  assign cmd_addr = cmd_d[DATA_WIDTH +: ADDR_WIDTH];
  assign cmd_data = cmd_d[DATA_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cs_prev_q    <= 1'b0;
      bit_cnt_q    <= '0;
      cmd_sr_q     <= '0;
      resp_sr_q    <= '0;
      resp_armed_q <= 1'b0;
      miso_q       <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_err_q  <= 1'b0;
      for (int i = 0; i < 2**ADDR_WIDTH; i++) regs_q[i] <= '0;
    end else begin
      cs_prev_q   <= cs_s;
      wr_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Only a real cs falling edge starts a frame, so a frame cut by reset is skipped
          if (cs_prev_q && !cs_s) begin
            state_q   <= ST_CMD;
            bit_cnt_q <= '0;
          end
        end
        ST_CMD: begin
          if (cs_s) begin
            state_q     <= ST_IDLE;
            frame_err_q <= 1'b1;
          end else if (rise) begin
            cmd_sr_q  <= cmd_d[CMD_WIDTH-2:0];
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == CNT_W'(CMD_WIDTH - 1)) begin
              if (cmd_rw == RW_READ) begin
                resp_sr_q    <= regs_q[cmd_addr];
                miso_q       <= regs_q[cmd_addr][DATA_WIDTH-1];
                resp_armed_q <= 1'b0;
                bit_cnt_q    <= '0;
                state_q      <= ST_RESP;
              end else begin
                regs_q[cmd_addr] <= cmd_data;
                wr_valid_q       <= 1'b1;
                wr_addr_q        <= cmd_addr;
                wr_data_q        <= cmd_data;
                state_q          <= ST_DONE;
              end
            end
          end
        end
        ST_RESP: begin
          if (cs_s) begin
            state_q     <= ST_IDLE;
            miso_q      <= 1'b0;
            frame_err_q <= 1'b1;
          end else if (rise) begin
            resp_armed_q <= 1'b1;
            bit_cnt_q    <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
              state_q <= ST_DONE;
              miso_q  <= 1'b0;
            end
          end else if (fall && resp_armed_q) begin
            // The fall trailing cmd bit 11 arrives unarmed and leaves the MSB in place
            resp_armed_q <= 1'b0;
            resp_sr_q    <= resp_sr_q << 1;
            miso_q       <= resp_sr_q[DATA_WIDTH-2];
          end
        end
        ST_DONE: begin
          miso_q <= 1'b0;
          if (cs_s) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign miso      = miso_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_slave_regfile.sv
// tb/tb_spi_slave_regfile.sv - bench SPI master at clk/10 with a register-file reference model
module tb_spi_slave_regfile;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, wr_valid, frame_err;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;

  spi_slave_regfile dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .cs       (cs),
    .mosi     (mosi),
    .miso     (miso),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: register contents and the last committed write
  logic [7:0] m_regs [8];
  logic [2:0] m_addr = '0;
  logic [7:0] m_data = '0;

  // 0 = bus idle, 1 = command bits, 2 = read response / in flux
  int phase = 2;

  int         wv_cnt = 0;
  int         fe_cnt = 0;
  logic [2:0] cap_addr = '0;
  logic [7:0] cap_data = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, #1 after the active edge
  always @(posedge clk) begin
    #1;
    if (wr_valid === 1'b1) begin
      wv_cnt++;
      cap_addr = wr_addr;
      cap_data = wr_data;
    end
    if (frame_err === 1'b1) fe_cnt++;
    if (!rst && phase == 0) begin
      check("idle_miso", {31'd0, miso}, 32'd0);
      check("idle_wr_valid", {31'd0, wr_valid}, 32'd0);
      check("idle_frame_err", {31'd0, frame_err}, 32'd0);
      check("idle_wr_addr", {29'd0, wr_addr}, {29'd0, m_addr});
      check("idle_wr_data", {24'd0, wr_data}, {24'd0, m_data});
    end else if (!rst && phase == 1) begin
      check("cmd_miso", {31'd0, miso}, 32'd0);
    end
  end

  task automatic bit_cycle(input logic b, output logic smp);
    sclk = 1'b0;
    mosi = b;
    repeat (5) @(negedge clk);
    smp  = miso;
    sclk = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic do_frame(input logic rw, input logic [2:0] a, input logic [7:0] d,
                          input int nbits, input bit rst_mid, output logic [7:0] rd);
    logic [11:0] f;
    logic        s;
    f = {rw, a, d};
    rd = '0;
    phase = 1;
    cs = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == nbits - 1 && nbits == 12) phase = 2;
      bit_cycle(f[RW_BIT-i], s);
    end
    sclk = 1'b0;
    if (nbits == 12 && rw == RW_READ) begin
      repeat (5) @(negedge clk);
      if (rst_mid) begin
        repeat (40) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_miso_now", {31'd0, miso}, 32'd0);
        for (int k = 0; k < 8; k++) m_regs[k] = '0;
        m_addr = '0;
        m_data = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (55) @(negedge clk);
      end else begin
        repeat (95) @(negedge clk);
      end
      for (int i = 0; i < 8; i++) begin
        bit_cycle(1'b0, s);
        rd = {rd[6:0], s};
      end
      sclk = 1'b0;
    end
    repeat (5) @(negedge clk);
    cs = 1'b1;
    repeat (5) @(negedge clk);
    if (nbits == 12 && rw == RW_WRITE) begin
      m_regs[a] = d;
      m_addr    = a;
      m_data    = d;
    end
    phase = 0;
    repeat (10) @(negedge clk);
  endtask

  // One frame with its outcome checked against the model
  task automatic run(input logic rw, input logic [2:0] a, input logic [7:0] d,
                     input int nbits, input bit rst_mid, output logic [7:0] rd);
    int         wv0, fe0;
    logic [7:0] exp_rd;
    wv0 = wv_cnt;
    fe0 = fe_cnt;
    exp_rd = m_regs[a];
    do_frame(rw, a, d, nbits, rst_mid, rd);
    check("wr_valid_pulses", wv_cnt - wv0, (nbits == 12 && rw == RW_WRITE) ? 1 : 0);
    check("frame_err_pulses", fe_cnt - fe0, (nbits < 12) ? 1 : 0);
    if (nbits == 12 && rw == RW_WRITE) begin
      check("wr_addr_cap", {29'd0, cap_addr}, {29'd0, a});
      check("wr_data_cap", {24'd0, cap_data}, {24'd0, d});
    end
    if (nbits == 12 && rw == RW_READ && !rst_mid)
      check("read_data", {24'd0, rd}, {24'd0, exp_rd});
  endtask

  initial begin
    logic [7:0] rd;
    int         sel;
    logic [2:0] ra;
    logic [7:0] rdat;
    for (int k = 0; k < 8; k++) m_regs[k] = '0;

    repeat (3) @(negedge clk);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_wr_addr", {29'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    phase = 0;
    repeat (5) @(negedge clk);

    // Read of a fresh register, write A5 to addr 5 and read it back
    run(1'b0, 3'd2, 8'h00, 12, 1'b0, rd);
    check("t3_read2_reset", {24'd0, rd}, 32'h00);
    run(1'b1, 3'd5, 8'hA5, 12, 1'b0, rd);
    check("t1_wr_addr", {29'd0, cap_addr}, 32'd5);
    check("t1_wr_data", {24'd0, cap_data}, 32'hA5);
    run(1'b0, 3'd5, 8'h00, 12, 1'b0, rd);
    check("t2_read5", {24'd0, rd}, 32'hA5);
    run(1'b1, 3'd2, 8'h3C, 12, 1'b0, rd);
    run(1'b0, 3'd2, 8'h00, 12, 1'b0, rd);
    check("t3_read2", {24'd0, rd}, 32'h3C);

    // Aborted write leaves addr 7 alone
    run(1'b1, 3'd7, 8'h5A, 6, 1'b0, rd);
    run(1'b0, 3'd7, 8'h00, 12, 1'b0, rd);
    check("t4_read7_after_abort", {24'd0, rd}, 32'h00);
    run(1'b1, 3'd7, 8'h11, 12, 1'b0, rd);
    run(1'b0, 3'd7, 8'h00, 12, 1'b0, rd);
    check("t4_read7", {24'd0, rd}, 32'h11);

    // Extreme addresses do not alias
    run(1'b1, 3'd0, 8'hFF, 12, 1'b0, rd);
    run(1'b1, 3'd7, 8'h80, 12, 1'b0, rd);
    run(1'b0, 3'd0, 8'h00, 12, 1'b0, rd);
    check("t5_read0", {24'd0, rd}, 32'hFF);
    run(1'b0, 3'd7, 8'h00, 12, 1'b0, rd);
    check("t5_read7", {24'd0, rd}, 32'h80);

    // Reset in the middle of a read response
    run(1'b0, 3'd5, 8'h00, 12, 1'b1, rd);
    for (int k = 0; k < 8; k++) begin
      run(1'b0, 3'(k), 8'h00, 12, 1'b0, rd);
      check("t6_read_after_rst", {24'd0, rd}, 32'h00);
    end
    run(1'b1, 3'd1, 8'h42, 12, 1'b0, rd);
    run(1'b0, 3'd1, 8'h00, 12, 1'b0, rd);
    check("t6_read1", {24'd0, rd}, 32'h42);

    // Randomized frames against the model
    for (int n = 0; n < 40; n++) begin
      sel  = int'($urandom_range(0, 9));
      ra   = 3'($urandom_range(0, 7));
      rdat = 8'($urandom_range(0, 255));
      if (sel < 4)      run(1'b1, ra, rdat, 12, 1'b0, rd);
      else if (sel < 8) run(1'b0, ra, rdat, 12, 1'b0, rd);
      else              run(1'($urandom_range(0, 1)), ra, rdat,
                            int'($urandom_range(1, 11)), 1'b0, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
